aclk_alarm_sequencer: RTL and testbench

Alarm ringing sequencer for the alarm clock. It compares the running time with the stored alarm time and drives the buzzer enable, and it handles user stop, snooze (with a repeat limit) and automatic ring timeout. It sits beside the key/display controller and consumes the same `one_second` tick, the current-time register and the alarm-time register outputs.

---
 rtl/aclk_alarm_sequencer_if.sv | 40 ++++
 rtl/aclk_alarm_sequencer.sv | 125 ++++++++++++
 tb/tb_aclk_alarm_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/aclk_alarm_sequencer_if.sv
// Signal bundle between the alarm sequencer and its controller:
// tick, alarm arm level, BCD times, user pulses in; buzzer and snooze status out.
interface aclk_alarm_sequencer_if;
    logic        one_second;
    logic        alarm_enable;
    logic [15:0] current_time;
    logic [15:0] alarm_time;
    logic        load_new_a;
    logic        stop_alarm;
    logic        snooze;
    logic        sound_alarm;
    logic        snoozing;
    logic [2:0]  snoozes_used;

    modport master (
        output one_second,
        output alarm_enable,
        output current_time,
        output alarm_time,
        output load_new_a,
        output stop_alarm,
        output snooze,
        input  sound_alarm,
        input  snoozing,
        input  snoozes_used
    );

    modport slave (
        input  one_second,
        input  alarm_enable,
        input  current_time,
        input  alarm_time,
        input  load_new_a,
        input  stop_alarm,
        input  snooze,
        output sound_alarm,
        output snoozing,
        output snoozes_used
    );
endinterface

// File: rtl/aclk_alarm_sequencer.sv
// Alarm ringing sequencer: triggers on a time match, then handles stop, limited
// snoozes and ring timeout, with a lockout until the matching minute has passed.
module aclk_alarm_sequencer #(
    parameter int RING_LIMIT_S = 60,
    parameter int SNOOZE_S     = 300,
    parameter int MAX_SNOOZES  = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    aclk_alarm_sequencer_if.slave         bus
);

    localparam logic [11:0] RING_LAST = 12'(RING_LIMIT_S - 1);
    localparam logic [11:0] SNZ_LAST  = 12'(SNOOZE_S - 1);
    localparam logic [2:0]  MAX_SNZ   = 3'(MAX_SNOOZES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [11:0] ring_cnt_reg, ring_cnt_next;
    logic [11:0] snz_cnt_reg, snz_cnt_next;
    logic [2:0]  used_reg, used_next;
    logic        sound_reg, snoozing_reg;

    // Full HH:MM compare, one BCD digit per lane.
    logic [3:0] digit_eq;
    logic       match;

    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        assign digit_eq[gi] = (bus.current_time[gi*4 +: 4] == bus.alarm_time[gi*4 +: 4]);
    end

    assign match = &digit_eq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            ring_cnt_reg <= 12'd0;
            snz_cnt_reg  <= 12'd0;
            used_reg     <= 3'd0;
            sound_reg    <= 1'b0;
            snoozing_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ring_cnt_reg <= ring_cnt_next;
            snz_cnt_reg  <= snz_cnt_next;
            used_reg     <= used_next;
            sound_reg    <= (state_next == RINGING);
            snoozing_reg <= (state_next == SNOOZE);
        end
    end

    always_comb begin
        state_next    = state_reg;
        ring_cnt_next = ring_cnt_reg;
        snz_cnt_next  = snz_cnt_reg;
        used_next     = used_reg;

        if (!bus.alarm_enable) begin
            state_next    = IDLE;
            ring_cnt_next = 12'd0;
            snz_cnt_next  = 12'd0;
            used_next     = 3'd0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (match && !bus.load_new_a) begin
                        state_next    = RINGING;
                        ring_cnt_next = 12'd0;
                    end
                end

                RINGING: begin
                    if (bus.stop_alarm || bus.load_new_a) begin
                        state_next = LOCKOUT;
                    end else if (bus.snooze && (used_reg < MAX_SNZ)) begin
                        state_next   = SNOOZE;
                        used_next    = used_reg + 3'd1;
                        snz_cnt_next = 12'd0;
                    end else if (bus.one_second) begin
                        // A snooze over the limit falls through here untouched.
                        if (ring_cnt_reg == RING_LAST) begin
                            state_next = LOCKOUT;
                        end else begin
                            ring_cnt_next = ring_cnt_reg + 12'd1;
                        end
                    end
                end

                SNOOZE: begin
                    if (bus.stop_alarm || bus.load_new_a) begin
                        state_next = LOCKOUT;
                    end else if (bus.one_second) begin
                        // Re-ring regardless of whether the minute still matches.
                        if (snz_cnt_reg == SNZ_LAST) begin
                            state_next    = RINGING;
                            ring_cnt_next = 12'd0;
                        end else begin
                            snz_cnt_next = snz_cnt_reg + 12'd1;
                        end
                    end
                end

                LOCKOUT: begin
                    if (!match) begin
                        state_next = IDLE;
                        used_next  = 3'd0;
                    end
                end

                default: state_next = IDLE;
            endcase
        end
    end

    assign bus.sound_alarm  = sound_reg;
    assign bus.snoozing     = snoozing_reg;
    assign bus.snoozes_used = used_reg;

endmodule

// File: tb/tb_aclk_alarm_sequencer.sv
// Directed bench for aclk_alarm_sequencer: a sequential vector table plus
// hand-written ring-timeout, snooze-cycle and asynchronous-reset sequences.
module tb_aclk_alarm_sequencer;

    logic clk;
    logic reset;
    int   tests;
    int   failed;

    aclk_alarm_sequencer_if bus_if ();

    aclk_alarm_sequencer #(
        .RING_LIMIT_S(60),
        .SNOOZE_S    (300),
        .MAX_SNOOZES (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic [15:0] cur;
        logic [15:0] alm;
        logic        load;
        logic        stop;
        logic        snz;
        logic        os;
        logic        exp_sound;
        logic        exp_snoozing;
        logic [2:0]  exp_used;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic os, input logic stop, input logic snz, input logic load);
        @(negedge clk);
        bus_if.one_second = os;
        bus_if.stop_alarm = stop;
        bus_if.snooze     = snz;
        bus_if.load_new_a = load;
        @(posedge clk);
        #1;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0);
            tick(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset               = 1'b1;
        bus_if.one_second   = 1'b0;
        bus_if.stop_alarm   = 1'b0;
        bus_if.snooze       = 1'b0;
        bus_if.load_new_a   = 1'b0;
        bus_if.alarm_enable = 1'b0;
        bus_if.current_time = 16'h0000;
        bus_if.alarm_time   = 16'h0000;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic ring_at_0730();
        bus_if.alarm_enable = 1'b1;
        bus_if.alarm_time   = 16'h0730;
        bus_if.current_time = 16'h0729;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        bus_if.current_time = 16'h0730;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        //            en  cur       alm       ld  st  sz  os   snd snzg used
        vecs[0]  = '{1'b1, 16'h0729, 16'h0730, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[1]  = '{1'b1, 16'h0730, 16'h0730, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
        vecs[2]  = '{1'b1, 16'h0730, 16'h0730, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1};
        vecs[3]  = '{1'b1, 16'h0730, 16'h0730, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1};
        vecs[4]  = '{1'b1, 16'h0730, 16'h0730, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1};
        vecs[5]  = '{1'b1, 16'h0730, 16'h0730, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1};
        vecs[6]  = '{1'b1, 16'h0730, 16'h0730, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1};
        vecs[7]  = '{1'b1, 16'h0731, 16'h0730, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[8]  = '{1'b1, 16'h0730, 16'h0730, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[9]  = '{1'b1, 16'h0730, 16'h0730, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
        vecs[10] = '{1'b0, 16'h0730, 16'h0730, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[11] = '{1'b1, 16'h0730, 16'h0730, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
        vecs[12] = '{1'b1, 16'h0730, 16'h0730, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[13] = '{1'b1, 16'h1359, 16'h2359, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[14] = '{1'b1, 16'h2358, 16'h2359, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[15] = '{1'b1, 16'h2359, 16'h2359, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
        vecs[16] = '{1'b1, 16'h2359, 16'h2359, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1};
        vecs[17] = '{1'b0, 16'h2359, 16'h2359, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[18] = '{1'b1, 16'h2359, 16'h2359, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
        vecs[19] = '{1'b1, 16'h2359, 16'h2359, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[20] = '{1'b1, 16'h2359, 16'h2359, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};

        reset = 1'b1;
        do_reset();
        #1;
        check("reset_sound", {15'd0, bus_if.sound_alarm}, 16'd0);
        check("reset_snoozing", {15'd0, bus_if.snoozing}, 16'd0);
        check("reset_used", {13'd0, bus_if.snoozes_used}, 16'd0);

        // Table: vectors are applied back to back, state carries over.
        for (int v = 0; v < NVEC; v++) begin
            @(negedge clk);
            bus_if.alarm_enable = vecs[v].en;
            bus_if.current_time = vecs[v].cur;
            bus_if.alarm_time   = vecs[v].alm;
            bus_if.load_new_a   = vecs[v].load;
            bus_if.stop_alarm   = vecs[v].stop;
            bus_if.snooze       = vecs[v].snz;
            bus_if.one_second   = vecs[v].os;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_sound", v), {15'd0, bus_if.sound_alarm}, {15'd0, vecs[v].exp_sound});
            check($sformatf("vec%0d_snoozing", v), {15'd0, bus_if.snoozing}, {15'd0, vecs[v].exp_snoozing});
            check($sformatf("vec%0d_used", v), {13'd0, bus_if.snoozes_used}, {13'd0, vecs[v].exp_used});
            $display("[TB] vec %0d en=%0b cur=%04h alm=%04h ld=%0b st=%0b sz=%0b os=%0b -> snd=%0b snzg=%0b used=%0d",
                     v, vecs[v].en, vecs[v].cur, vecs[v].alm, vecs[v].load, vecs[v].stop,
                     vecs[v].snz, vecs[v].os, bus_if.sound_alarm, bus_if.snoozing, bus_if.snoozes_used);
        end

        // Ring timeout; the pulse on the entry cycle is not counted.
        do_reset();
        bus_if.alarm_enable = 1'b1;
        bus_if.alarm_time   = 16'h0730;
        bus_if.current_time = 16'h0729;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("to_pre_match", {15'd0, bus_if.sound_alarm}, 16'd0);
        bus_if.current_time = 16'h0730;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("to_trigger", {15'd0, bus_if.sound_alarm}, 16'd1);
        pulses(59);
        check("to_after59", {15'd0, bus_if.sound_alarm}, 16'd1);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("to_expire", {15'd0, bus_if.sound_alarm}, 16'd0);
        check("to_expire_snoozing", {15'd0, bus_if.snoozing}, 16'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("to_lockout_hold", {15'd0, bus_if.sound_alarm}, 16'd0);
        bus_if.current_time = 16'h0731;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("to_0731", {15'd0, bus_if.sound_alarm}, 16'd0);
        bus_if.current_time = 16'h0730;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("to_idle_rearmed", {15'd0, bus_if.sound_alarm}, 16'd1);
        $display("[TB] seq ring_timeout done");

        // Three full snooze cycles, then a fourth snooze is ignored.
        do_reset();
        ring_at_0730();
        check("sz_ring", {15'd0, bus_if.sound_alarm}, 16'd1);
        for (int k = 1; k <= 3; k++) begin
            tick(1'b1, 1'b0, 1'b1, 1'b0);
            check($sformatf("sz%0d_enter_sound", k), {15'd0, bus_if.sound_alarm}, 16'd0);
            check($sformatf("sz%0d_enter_snoozing", k), {15'd0, bus_if.snoozing}, 16'd1);
            check($sformatf("sz%0d_used", k), {13'd0, bus_if.snoozes_used}, 16'(k));
            pulses(299);
            check($sformatf("sz%0d_after299", k), {15'd0, bus_if.snoozing}, 16'd1);
            tick(1'b1, 1'b0, 1'b0, 1'b0);
            check($sformatf("sz%0d_rering", k), {15'd0, bus_if.sound_alarm}, 16'd1);
            check($sformatf("sz%0d_rering_snoozing", k), {15'd0, bus_if.snoozing}, 16'd0);
            $display("[TB] seq snooze %0d done used=%0d", k, bus_if.snoozes_used);
        end
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        check("sz4_ignored_sound", {15'd0, bus_if.sound_alarm}, 16'd1);
        check("sz4_ignored_used", {13'd0, bus_if.snoozes_used}, 16'd3);
        pulses(59);
        check("sz4_ring59", {15'd0, bus_if.sound_alarm}, 16'd1);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("sz4_expire", {15'd0, bus_if.sound_alarm}, 16'd0);
        check("sz4_lockout_used", {13'd0, bus_if.snoozes_used}, 16'd3);
        bus_if.current_time = 16'h0731;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("sz4_used_cleared", {13'd0, bus_if.snoozes_used}, 16'd0);
        $display("[TB] seq snooze_limit done");

        // Asynchronous reset while ringing.
        do_reset();
        ring_at_0730();
        check("ar_ring", {15'd0, bus_if.sound_alarm}, 16'd1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("ar_async_sound", {15'd0, bus_if.sound_alarm}, 16'd0);
        check("ar_async_snoozing", {15'd0, bus_if.snoozing}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        $display("[TB] seq async_reset done");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
